regbank_write_arbiter: RTL and testbench



---
 rtl/regbank_write_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_regbank_write_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regbank_write_arbiter
//  Purpose  : Byte-wide register bank whose single write port is shared by two
//             requesters under round-robin arbitration with an optional
//             per-requester lock. Accepted writes pass through a one-entry
//             pending register before committing. The block also provides one
//             combinational read port and a saturating stall counter.
//  Options  : REGBANK_WRITE_BYPASS_EN - the read port forwards the pending
//             entry so that a write is visible one edge after acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_write_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int STALL_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              pend_valid,
  output logic [1:0]        lock_owner,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t state;
  logic   last;   // index of the requester that was served most recently

  logic   grant0;
  logic   grant1;
  logic   xfer0;
  logic   xfer1;

  logic [ADDR_W-1:0]               pend_addr;
  logic [DATA_W-1:0]               pend_data;
  logic [NUM_REGS-1:0][DATA_W-1:0] bank;

  // Grant decision: depends only on valids, FSM state and last (never on data/addr)
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          // tie goes to whichever requester was not served last
          grant0 = last;
          grant1 = ~last;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
      ST_LOCK0: grant0 = req0_valid;
      ST_LOCK1: grant1 = req1_valid;
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  // Ready is suppressed while reset is asserted so no transfer is ever seen under reset
  assign req0_ready = grant0 & reset;
  assign req1_ready = grant1 & reset;
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;

  // Arbitration FSM with registered lock owner and round-robin history
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last       <= 1'b1;
      lock_owner <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer0) begin
            last <= 1'b0;
            if (req0_lock) begin
              state      <= ST_LOCK0;
              lock_owner <= 2'b01;
            end
          end else if (xfer1) begin
            last <= 1'b1;
            if (req1_lock) begin
              state      <= ST_LOCK1;
              lock_owner <= 2'b10;
            end
          end
        end
        ST_LOCK0: begin
          if (xfer0) begin
            last <= 1'b0;
            if (!req0_lock) begin
              state      <= ST_IDLE;
              lock_owner <= 2'b00;
            end
          end else if (!req0_lock) begin
            // owner released the lock without transferring
            last       <= 1'b0;
            state      <= ST_IDLE;
            lock_owner <= 2'b00;
          end
        end
        ST_LOCK1: begin
          if (xfer1) begin
            last <= 1'b1;
            if (!req1_lock) begin
              state      <= ST_IDLE;
              lock_owner <= 2'b00;
            end
          end else if (!req1_lock) begin
            last       <= 1'b1;
            state      <= ST_IDLE;
            lock_owner <= 2'b00;
          end
        end
        default: begin
          state      <= ST_IDLE;
          lock_owner <= 2'b00;
        end
      endcase
    end
  end

  // Pending register and bank commit; a reload in the commit cycle keeps one write per cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      bank       <= '0;
    end else begin
      if (pend_valid) begin
        bank[pend_addr] <= pend_data;
      end
      if (xfer0) begin
        pend_valid <= 1'b1;
        pend_addr  <= req0_addr;
        pend_data  <= req0_data;
      end else if (xfer1) begin
        pend_valid <= 1'b1;
        pend_addr  <= req1_addr;
        pend_data  <= req1_data;
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Debug stall counter: counts edges where some requester waits, sticks at all-ones
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (((req0_valid && !req0_ready) || (req1_valid && !req1_ready)) &&
                 (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Read port, optionally forwarding the not-yet-committed pending entry
  always_comb begin
    rd_data = bank[rd_addr];
`ifdef REGBANK_WRITE_BYPASS_EN
    if (pend_valid && (rd_addr == pend_addr)) begin
      rd_data = pend_data;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_write_arbiter
//  Purpose  : Self-checking bench for regbank_write_arbiter: directed vector
//             table plus hand-written reset, mid-pipeline reset and long
//             contention sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_write_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req0_lock, req0_ready;
  logic [2:0] req0_addr;
  logic [7:0] req0_data;
  logic       req1_valid, req1_lock, req1_ready;
  logic [2:0] req1_addr;
  logic [7:0] req1_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       pend_valid;
  logic [1:0] lock_owner;
  logic [7:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  regbank_write_arbiter #(
    .NUM_REGS(8), .ADDR_W(3), .DATA_W(8), .STALL_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .pend_valid(pend_valid),
    .lock_owner(lock_owner), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0, l0; logic [2:0] a0; logic [7:0] d0;
    logic       v1, l1; logic [2:0] a1; logic [7:0] d1;
    logic [2:0] ra;
    logic       r0, r1; logic [1:0] lo; logic pv; logic [7:0] st;
    logic [7:0] rd;     // expected read data, plain build
    logic [7:0] rdb;    // expected read data, bypass build
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic v0, logic l0, logic [2:0] a0, logic [7:0] d0,
                              logic v1, logic l1, logic [2:0] a1, logic [7:0] d1,
                              logic [2:0] ra, logic r0, logic r1, logic [1:0] lo,
                              logic pv, logic [7:0] st, logic [7:0] rd, logic [7:0] rdb);
    vec_t v;
    v.v0 = v0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.ra = ra; v.r0 = r0; v.r1 = r1; v.lo = lo; v.pv = pv; v.st = st;
    v.rd = rd; v.rdb = rdb;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    req0_valid = 0; req0_lock = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_lock = 0; req1_addr = 0; req1_data = 0;
  endtask

  function automatic logic [7:0] pick_rd(vec_t v);
`ifdef REGBANK_WRITE_BYPASS_EN
    return v.rdb;
`else
    return v.rd;
`endif
  endfunction

  initial begin
    // state after reset: IDLE, last=1, bank all zero, stall 0
    vecs[0]  = mk(1,0,3,8'hA5, 0,0,0,8'h00, 3, 1,0,2'b00,0,0, 8'h00,8'h00);
    vecs[1]  = mk(0,0,0,8'h00, 1,0,7,8'h77, 3, 0,1,2'b00,1,0, 8'h00,8'hA5);
    vecs[2]  = mk(1,0,1,8'h11, 1,0,2,8'h22, 3, 1,0,2'b00,1,0, 8'hA5,8'hA5);
    vecs[3]  = mk(0,0,0,8'h00, 1,0,2,8'h22, 7, 0,1,2'b00,1,1, 8'h77,8'h77);
    vecs[4]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 1, 0,0,2'b00,1,1, 8'h11,8'h11);
    vecs[5]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 2, 0,0,2'b00,0,1, 8'h22,8'h22);
    vecs[6]  = mk(1,0,0,8'h5A, 0,0,0,8'h00, 0, 1,0,2'b00,0,1, 8'h00,8'h00);
    vecs[7]  = mk(1,0,0,8'hC3, 1,1,4,8'h44, 0, 0,1,2'b00,1,1, 8'h00,8'h5A);
    vecs[8]  = mk(1,0,0,8'hC3, 1,1,5,8'h55, 4, 0,1,2'b10,1,2, 8'h00,8'h44);
    vecs[9]  = mk(1,0,0,8'hC3, 1,0,6,8'h66, 4, 0,1,2'b10,1,3, 8'h44,8'h44);
    vecs[10] = mk(1,0,0,8'hC3, 0,0,0,8'h00, 5, 1,0,2'b00,1,4, 8'h55,8'h55);
    vecs[11] = mk(0,0,0,8'h00, 0,0,0,8'h00, 6, 0,0,2'b00,1,4, 8'h66,8'h66);
    vecs[12] = mk(0,0,0,8'h00, 0,0,0,8'h00, 0, 0,0,2'b00,0,4, 8'hC3,8'hC3);
    vecs[13] = mk(1,1,1,8'hE1, 0,0,0,8'h00, 1, 1,0,2'b00,0,4, 8'h11,8'h11);
    vecs[14] = mk(0,1,0,8'h00, 1,0,2,8'hB2, 1, 0,0,2'b01,1,4, 8'h11,8'hE1);
    vecs[15] = mk(0,0,0,8'h00, 1,0,2,8'hB2, 1, 0,0,2'b01,0,5, 8'hE1,8'hE1);
    vecs[16] = mk(0,0,0,8'h00, 1,0,2,8'hB2, 2, 0,1,2'b00,0,6, 8'h22,8'h22);
    vecs[17] = mk(0,0,0,8'h00, 0,0,0,8'h00, 2, 0,0,2'b00,1,6, 8'h22,8'hB2);
    vecs[18] = mk(0,0,0,8'h00, 0,0,0,8'h00, 2, 0,0,2'b00,0,6, 8'hB2,8'hB2);
    vecs[19] = mk(1,0,3,8'h01, 0,0,0,8'h00, 3, 1,0,2'b00,0,6, 8'hA5,8'hA5);
    vecs[20] = mk(1,0,3,8'h02, 0,0,0,8'h00, 3, 1,0,2'b00,1,6, 8'hA5,8'h01);
    vecs[21] = mk(0,0,0,8'h00, 0,0,0,8'h00, 3, 0,0,2'b00,1,6, 8'h01,8'h02);
    vecs[22] = mk(0,0,0,8'h00, 0,0,0,8'h00, 3, 0,0,2'b00,0,6, 8'h02,8'h02);

    // ---------------- reset, ready held low while reset asserted ----------
    reset = 0; drive_idle(); rd_addr = 0;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk); #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(negedge clk); #1;
    chk("rst_pend", pend_valid, 0);
    chk("rst_lock", lock_owner, 0);
    chk("rst_stall", stall_cnt, 0);
    drive_idle();
    reset = 1;
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      rd_addr = 3'(a);
      #1;
      chk($sformatf("rst_rd[%0d]", a), rd_data, 0);
    end

    // ---------------- directed vector table --------------------------------
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      req0_valid = vecs[i].v0; req0_lock = vecs[i].l0;
      req0_addr  = vecs[i].a0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_lock = vecs[i].l1;
      req1_addr  = vecs[i].a1; req1_data = vecs[i].d1;
      rd_addr    = vecs[i].ra;
      #1;
      chk($sformatf("v%0d_ready0", i), req0_ready, vecs[i].r0);
      chk($sformatf("v%0d_ready1", i), req1_ready, vecs[i].r1);
      chk($sformatf("v%0d_lock", i), lock_owner, vecs[i].lo);
      chk($sformatf("v%0d_pend", i), pend_valid, vecs[i].pv);
      chk($sformatf("v%0d_stall", i), stall_cnt, vecs[i].st);
      chk($sformatf("v%0d_rd", i), rd_data, pick_rd(vecs[i]));
    end

    // ---------------- reset one edge after a transfer ----------------------
    @(negedge clk);
    drive_idle();
    req0_valid = 1; req0_addr = 5; req0_data = 8'hEE; rd_addr = 5;
    #1;
    chk("mid_xfer_ready", req0_ready, 1);
    @(negedge clk);
    reset = 0;
    req0_valid = 1; req0_addr = 6; req0_data = 8'h66;
    req1_valid = 1; req1_addr = 7; req1_data = 8'h77;
    #1;
    chk("mid_pend_before", pend_valid, 1);
    chk("mid_rst_ready0", req0_ready, 0);
    chk("mid_rst_ready1", req1_ready, 0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("mid_pend_after", pend_valid, 0);
    chk("mid_rd_after", rd_data, 0);
    chk("mid_stall", stall_cnt, 0);
    reset = 1;
    @(negedge clk); #1;
    chk("mid_rd_later", rd_data, 0);
    chk("mid_pend_later", pend_valid, 0);

    // ---------------- long contention: alternation and saturation ----------
    // after reset last=1, so req0 takes the first grant
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      req0_valid = 1; req0_addr = 3'((k + 1) / 2); req0_data = 8'((k + 1) / 2);
      req1_valid = 1; req1_addr = 3'(k / 2);       req1_data = 8'(k / 2);
      #1;
      chk($sformatf("rr%0d_ready0", k), req0_ready, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_ready1", k), req1_ready, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("rr%0d_stall", k), stall_cnt, (k > 255) ? 255 : k);
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("rr_stall_sat", stall_cnt, 8'hFF);
    @(negedge clk); #1;
    chk("rr_stall_hold", stall_cnt, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
